// File: rtl/m_irqagg_pkg.sv
// m_irqagg_pkg: constants shared by the interrupt aggregator and its
// priority encoder.
//   ADR_* : bus word selects for the four aggregator registers.
//   id_width(n) : width needed to carry a claim id in the range 0..n.
package m_irqagg_pkg;

  localparam logic [1:0] ADR_PENDING   = 2'd0;
  localparam logic [1:0] ADR_ENABLE    = 2'd1;
  localparam logic [1:0] ADR_CLAIM     = 2'd2;
  localparam logic [1:0] ADR_INSERVICE = 2'd3;

  // Id 0 means "nothing to claim", so the id has to hold NCHAN+1 values.
  function automatic int id_width(input int nchan);
    return $clog2(nchan + 1);
  endfunction

endpackage

// File: rtl/m_irqagg_prienc.sv
// m_irqagg_prienc: combinational lowest-index priority encoder.
//   req_i : one request bit per channel
//   id_o  : index+1 of the lowest set request bit, 0 when no bit is set
module m_irqagg_prienc
  import m_irqagg_pkg::*;
#(
  parameter int NCHAN = 8,
  parameter int IDW   = id_width(NCHAN)
) (
  input  logic [NCHAN-1:0] req_i,
  output logic [IDW-1:0]   id_o
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    id_o = {IDW{1'b0}};
    for (int i = NCHAN - 1; i >= 0; i--) begin
      id_o = req_i[i] ? IDW'(i + 1) : id_o;
    end
  end

endmodule

// File: rtl/m_irqagg.sv
// m_irqagg: external interrupt aggregator for the midgetv core.
//   CLK_I, RST_I         : clock, asynchronous active-high reset
//   STB_I, WE_I, ADR_I   : single-word bus access (0 PENDING, 1 ENABLE,
//                          2 CLAIM, 3 INSERVICE)
//   DAT_I, DAT_O, ACK_O  : bus data in/out and one-cycle acknowledge
//   irq_i                : raw interrupt sources, one per channel
//   meip                 : registered machine external interrupt pending
// Parameters: NCHAN channels; EDGEMASK bit=1 selects rising-edge capture,
// bit=0 selects level following.
// Build option: define M_IRQAGG_SYNC_EN to put a two-flop synchroniser on
// every irq_i bit (irq_i to meip latency 4 edges instead of 2).
module m_irqagg
  import m_irqagg_pkg::*;
#(
  parameter int               NCHAN    = 8,
  parameter logic [NCHAN-1:0] EDGEMASK = {NCHAN{1'b0}}
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             STB_I,
  input  logic             WE_I,
  input  logic [1:0]       ADR_I,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK_O,
  input  logic [NCHAN-1:0] irq_i,
  output logic             meip
);

  localparam int IDW = id_width(NCHAN);

  logic [NCHAN-1:0] s;
  logic [NCHAN-1:0] prev_q, prev_d;
  logic [NCHAN-1:0] pending_q, pending_d;
  logic [NCHAN-1:0] enable_q, enable_d;
  logic [NCHAN-1:0] inservice_q, inservice_d;
  logic             meip_q, meip_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [NCHAN-1:0] cand;
  logic [NCHAN-1:0] clr;
  logic [IDW-1:0]   claim_id;
  logic             access;

`ifdef M_IRQAGG_SYNC_EN
  logic [NCHAN-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for asynchronous interrupt sources.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sync1_q <= {NCHAN{1'b0}};
      sync2_q <= {NCHAN{1'b0}};
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = irq_i;
`endif

  assign cand = pending_q & enable_q & ~inservice_q;

  m_irqagg_prienc #(
    .NCHAN (NCHAN),
    .IDW   (IDW)
  ) u_prienc (
    .req_i (cand),
    .id_o  (claim_id)
  );

  // Next-state for bus handshake, register side effects and pending capture.
  always_comb begin
    prev_d      = s;
    access      = STB_I & ~ack_q;
    ack_d       = access;
    meip_d      = |cand;
    enable_d    = enable_q;
    inservice_d = inservice_q;
    dat_d       = 32'd0;
    clr         = {NCHAN{1'b0}};

    if (access) begin
      if (WE_I) begin
        case (ADR_I)
          // Write-1-to-clear only reaches edge channels.
          ADR_PENDING: clr = DAT_I[NCHAN-1:0] & EDGEMASK;
          ADR_ENABLE:  enable_d = DAT_I[NCHAN-1:0];
          // Completion: ids outside 1..NCHAN match no channel and fall away.
          ADR_CLAIM: begin
            for (int i = 0; i < NCHAN; i++) begin
              inservice_d[i] = (DAT_I == 32'(i + 1)) ? 1'b0 : inservice_q[i];
            end
          end
          default: clr = {NCHAN{1'b0}};
        endcase
      end else begin
        case (ADR_I)
          ADR_PENDING: dat_d = {{(32 - NCHAN){1'b0}}, pending_q};
          ADR_ENABLE:  dat_d = {{(32 - NCHAN){1'b0}}, enable_q};
          ADR_CLAIM: begin
            dat_d = 32'(claim_id);
            for (int i = 0; i < NCHAN; i++) begin
              inservice_d[i] = (claim_id == IDW'(i + 1)) ? 1'b1 : inservice_q[i];
              clr[i]         = (claim_id == IDW'(i + 1)) & EDGEMASK[i];
            end
          end
          default: dat_d = {{(32 - NCHAN){1'b0}}, inservice_q};
        endcase
      end
    end else begin
      dat_d = 32'd0;
    end

    // A new edge outranks any clear landing on the same cycle.
    for (int i = 0; i < NCHAN; i++) begin
      if (EDGEMASK[i]) begin
        pending_d[i] = (pending_q[i] & ~clr[i]) | (s[i] & ~prev_q[i]);
      end else begin
        pending_d[i] = s[i];
      end
    end
  end

  // State and output registers; prev resets high so a source already high
  // at reset release is not mistaken for an edge.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      prev_q      <= {NCHAN{1'b1}};
      pending_q   <= {NCHAN{1'b0}};
      enable_q    <= {NCHAN{1'b0}};
      inservice_q <= {NCHAN{1'b0}};
      meip_q      <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= 32'd0;
    end else begin
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      inservice_q <= inservice_d;
      meip_q      <= meip_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign DAT_O = dat_q;
  assign ACK_O = ack_q;
  assign meip  = meip_q;

endmodule

// File: tb/tb_m_irqagg.sv
module tb_m_irqagg;

`ifdef M_IRQAGG_SYNC_EN
  localparam int LAT  = 4;
  localparam bit SYNC = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit SYNC = 1'b0;
`endif
  localparam logic [7:0] EMASK = 8'h0F;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic [1:0]  ADR_I = 2'd0;
  logic [31:0] DAT_I = 32'd0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic [7:0]  irq_i = 8'h00;
  logic        meip;

  int total = 0;
  int bad   = 0;

  m_irqagg #(.NCHAN(8), .EDGEMASK(EMASK)) dut (
    .CLK_I (CLK_I), .RST_I (RST_I), .STB_I (STB_I), .WE_I (WE_I),
    .ADR_I (ADR_I), .DAT_I (DAT_I), .DAT_O (DAT_O), .ACK_O (ACK_O),
    .irq_i (irq_i), .meip (meip)
  );

  always #5 CLK_I = ~CLK_I;

  // ---------------- behavioural model ----------------
  bit [7:0]  m_pend, m_en, m_ins, m_prev, m_sy1, m_sy2;
  bit        m_meip, m_ack, m_init;
  bit [31:0] m_dat;

  always @(posedge CLK_I) begin
    bit [7:0]  sv, cand, clrv, np, ne, ni;
    bit [31:0] nd;
    int        id, k;
    bit        acc;
    if (RST_I) begin
      m_pend = 8'h00; m_en = 8'h00; m_ins = 8'h00; m_prev = 8'hFF;
      m_sy1 = 8'h00; m_sy2 = 8'h00; m_meip = 1'b0; m_ack = 1'b0;
      m_dat = 32'd0; m_init = 1'b1;
    end else begin
      sv   = SYNC ? m_sy2 : irq_i;
      cand = m_pend & m_en & ~m_ins;
      id   = 0;
      for (int c = 0; c < 8; c++) if (cand[c] && id == 0) id = c + 1;
      acc  = STB_I && !m_ack;
      clrv = 8'h00; ne = m_en; ni = m_ins; nd = 32'd0;
      if (acc) begin
        if (WE_I) begin
          case (ADR_I)
            2'd0: clrv = DAT_I[7:0] & EMASK;
            2'd1: ne = DAT_I[7:0];
            2'd2: begin
              k = int'(DAT_I);
              if (DAT_I >= 32'd1 && DAT_I <= 32'd8) ni[k-1] = 1'b0;
            end
            default: ;
          endcase
        end else begin
          case (ADR_I)
            2'd0: nd = {24'd0, m_pend};
            2'd1: nd = {24'd0, m_en};
            2'd2: begin
              nd = 32'(id);
              if (id != 0) begin
                ni[id-1] = 1'b1;
                clrv[id-1] = EMASK[id-1];
              end
            end
            default: nd = {24'd0, m_ins};
          endcase
        end
      end
      for (int c = 0; c < 8; c++)
        np[c] = EMASK[c] ? ((m_pend[c] && !clrv[c]) || (sv[c] && !m_prev[c])) : sv[c];
      m_meip = |cand; m_ack = acc; m_dat = nd;
      m_pend = np; m_en = ne; m_ins = ni; m_prev = sv;
      m_sy2 = m_sy1; m_sy1 = irq_i;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge CLK_I) begin
    if (!RST_I && m_init) begin
      total++;
      if (ACK_O !== m_ack) begin
        bad++; $display("FAIL cyc_ack act=%b exp=%b t=%0t", ACK_O, m_ack, $time);
      end
      total++;
      if (meip !== m_meip) begin
        bad++; $display("FAIL cyc_meip act=%b exp=%b t=%0t", meip, m_meip, $time);
      end
      if (m_ack) begin
        total++;
        if (DAT_O !== m_dat) begin
          bad++; $display("FAIL cyc_dat act=%h exp=%h t=%0t", DAT_O, m_dat, $time);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                     output logic [31:0] rd);
    bit got = 1'b0;
    rd = 32'hDEADBEEF;
    @(negedge CLK_I);
    STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge CLK_I);
      if (ACK_O) begin
        got = 1'b1;
        rd  = DAT_O;
      end
    end
    STB_I = 1'b0; WE_I = 1'b0; DAT_I = 32'd0;
    if (!got) begin
      total++; bad++;
      $display("FAIL bus_ack_timeout act=0 exp=1 adr=%0d", adr);
    end
  endtask

  task automatic rd_chk(input string name, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, adr, 32'd0, v);
    chk(name, v, exp);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
    logic [31:0] v;
    bus(1'b1, adr, dat, v);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int acks;
    repeat (2) @(negedge CLK_I);
    #2 RST_I = 1'b0;

    // Reset state
    @(negedge CLK_I);
    chk("rst_meip", {31'd0, meip}, 32'd0);
    chk("rst_ack", {31'd0, ACK_O}, 32'd0);
    chk("rst_dat", DAT_O, 32'd0);
    rd_chk("rst_pending", 2'd0, 32'h0);
    rd_chk("rst_enable", 2'd1, 32'h0);
    rd_chk("rst_inservice", 2'd3, 32'h0);
    rd_chk("rst_claim_none", 2'd2, 32'h0);

    // One-cycle pulse on edge channel 0, measure latency to meip
    wr(2'd1, 32'h01);
    @(negedge CLK_I);
    irq_i[0] = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK_I); #1;
      n++;
      if (n == 1) irq_i[0] = 1'b0;
      if (meip) break;
    end
    chk("meip_latency", 32'(n), 32'(LAT));
    repeat (3) @(negedge CLK_I);
    chk("meip_hold", {31'd0, meip}, 32'd1);
    rd_chk("pending_edge0", 2'd0, 32'h01);
    wr(2'd0, 32'h01);
    rd_chk("pending_w1c", 2'd0, 32'h00);

    // Claim priority
    wr(2'd1, 32'hFF);
    @(negedge CLK_I);
    irq_i[5] = 1'b1; irq_i[2] = 1'b1;
    repeat (LAT + 2) @(negedge CLK_I);
    rd_chk("claim_first", 2'd2, 32'd3);
    rd_chk("inservice_2", 2'd3, 32'h04);
    rd_chk("claim_second", 2'd2, 32'd6);
    rd_chk("inservice_25", 2'd3, 32'h24);
    rd_chk("pending_after_claim", 2'd0, 32'h20);
    irq_i[5] = 1'b0; irq_i[2] = 1'b0;
    wr(2'd2, 32'd3);
    wr(2'd2, 32'd6);
    rd_chk("inservice_done", 2'd3, 32'h00);

    // Claim/complete of channel 1, with ignored ids
    @(negedge CLK_I);
    irq_i[1] = 1'b1;
    @(negedge CLK_I);
    irq_i[1] = 1'b0;
    repeat (LAT + 1) @(negedge CLK_I);
    rd_chk("claim_ch1", 2'd2, 32'd2);
    rd_chk("inservice_ch1", 2'd3, 32'h02);
    rd_chk("pending_ch1_cleared", 2'd0, 32'h00);
    wr(2'd2, 32'd9);
    rd_chk("complete_id9_ignored", 2'd3, 32'h02);
    wr(2'd2, 32'd0);
    rd_chk("complete_id0_ignored", 2'd3, 32'h02);
    wr(2'd3, 32'h00);
    rd_chk("inservice_readonly", 2'd3, 32'h02);
    wr(2'd2, 32'd2);
    rd_chk("complete_ch1", 2'd3, 32'h00);

    // W1C on the very edge where channel 1 rises: set wins
    @(posedge CLK_I); #1;
    irq_i[1] = 1'b1;
    repeat (LAT - 2) @(posedge CLK_I);
    wr(2'd0, 32'h02);
    rd_chk("w1c_vs_edge", 2'd0, 32'h02);
    irq_i[1] = 1'b0;
    wr(2'd1, 32'h00);
    rd_chk("disable_keeps_pending", 2'd0, 32'h02);
    wr(2'd0, 32'hFF);
    rd_chk("w1c_all", 2'd0, 32'h00);

    // Level channel ignores W1C
    irq_i[6] = 1'b1;
    repeat (LAT + 1) @(negedge CLK_I);
    wr(2'd0, 32'h40);
    rd_chk("level_w1c_noeffect", 2'd0, 32'h40);
    irq_i[6] = 1'b0;
    repeat (LAT + 1) @(negedge CLK_I);
    rd_chk("level_follows_low", 2'd0, 32'h00);

    // Inputs held high through reset release
    irq_i = 8'hFF;
    @(negedge CLK_I); #2 RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    #2 RST_I = 1'b0;
    repeat (LAT + 1) @(negedge CLK_I);
    rd_chk("high_at_release", 2'd0, SYNC ? 32'hFF : 32'hF0);
    rd_chk("enable_after_rst", 2'd1, 32'h00);
    irq_i = 8'h00;
    repeat (LAT + 1) @(negedge CLK_I);

    // Reset in the middle of an access discards it
    @(negedge CLK_I);
    STB_I = 1'b1; WE_I = 1'b0; ADR_I = 2'd0;
    #2 RST_I = 1'b1;
    STB_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    #2 RST_I = 1'b0;
    acks = 0;
    repeat (5) begin
      @(negedge CLK_I);
      if (ACK_O) acks++;
    end
    chk("rst_mid_access_no_ack", 32'(acks), 32'd0);
    rd_chk("bus_alive_after_rst", 2'd1, 32'h00);

    repeat (3) @(negedge CLK_I);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
